led_shift_out: RTL and testbench



---
 rtl/led_shift_out_if.sv | 11 +
 rtl/led_shift_out.sv | 196 +++++++++++++++++++
 tb/tb_led_shift_out.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/led_shift_out_if.sv
// Three-wire serial bus to the daisy-chained LED driver board, plus the frame-busy flag.
// The master side is the serialiser; the slave side is the board (or a monitor).
interface led_shift_out_if;
   logic ser_clk;
   logic ser_data;
   logic ser_latch;
   logic busy;

   modport master (output ser_clk, output ser_data, output ser_latch, output busy);
   modport slave  (input  ser_clk, input  ser_data, input  ser_latch, input  busy);
endinterface

// File: rtl/led_shift_out.sv
// Serialises {sl_in, disp_1..disp_8} (73 bits, MSB first) to a shift-register LED driver chain,
// sending a frame only when the inputs change and once after reset. Optional SEG_INVERT_EN inverts segment bits.
module led_shift_out #(
   parameter int CLK_DIV = 4,
   parameter int LATCH_W = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            disp_1,
   input  logic [7:0]            disp_2,
   input  logic [7:0]            disp_3,
   input  logic [7:0]            disp_4,
   input  logic [7:0]            disp_5,
   input  logic [7:0]            disp_6,
   input  logic [7:0]            disp_7,
   input  logic [7:0]            disp_8,
   input  logic [8:0]            sl_in,
   led_shift_out_if.master       sout
);

   localparam int DIV_W = $clog2(2 * CLK_DIV);
   localparam int LAT_W = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX_C = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HI_C  = DIV_W'(CLK_DIV - 1);
   localparam logic [LAT_W-1:0] LAT_MAX_C = LAT_W'(LATCH_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [72:0]       frame_s;
   logic [72:0]       tx_s;
   logic [72:0]       shift_r;
   logic [72:0]       last_sent_r;
   logic              init_pending_r;
   logic [6:0]        bit_cnt_r;
   logic [DIV_W-1:0]  div_cnt_r;
   logic [LAT_W-1:0]  latch_cnt_r;
   logic              start_s;
   logic              bit_end_s;
   logic              last_bit_s;
   logic              latch_end_s;
   logic              ser_clk_r, ser_clk_s;
   logic              ser_data_r, ser_data_s;
   logic              ser_latch_r, ser_latch_s;
   logic              busy_r, busy_s;

   assign frame_s = {sl_in, disp_1, disp_2, disp_3, disp_4, disp_5, disp_6, disp_7, disp_8};

`ifdef SEG_INVERT_EN
   // Common-anode boards: segment bits go out inverted, select bits never do.
   assign tx_s = {frame_s[72:64], ~frame_s[63:0]};
`else
   assign tx_s = frame_s;
`endif

   // Change detection always uses the raw inputs, independent of inversion.
   assign start_s     = (state_r == IDLE) && (init_pending_r || (frame_s != last_sent_r));
   assign bit_end_s   = (div_cnt_r == DIV_MAX_C);
   assign last_bit_s  = (bit_cnt_r == 7'd0);
   assign latch_end_s = (latch_cnt_r == LAT_MAX_C);

   // State and registered serial outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         ser_clk_r   <= 1'b0;
         ser_data_r  <= 1'b0;
         ser_latch_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         ser_clk_r   <= ser_clk_s;
         ser_data_r  <= ser_data_s;
         ser_latch_r <= ser_latch_s;
         busy_r      <= busy_s;
      end
   end

   // Frame capture, shift register and bit/phase/latch counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_r        <= 73'd0;
         last_sent_r    <= 73'd0;
         init_pending_r <= 1'b1;
         bit_cnt_r      <= 7'd0;
         div_cnt_r      <= '0;
         latch_cnt_r    <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  shift_r        <= tx_s;
                  last_sent_r    <= frame_s;
                  init_pending_r <= 1'b0;
                  bit_cnt_r      <= 7'd72;
                  div_cnt_r      <= '0;
               end
            end
            SHIFT: begin
               if (bit_end_s) begin
                  div_cnt_r   <= '0;
                  shift_r     <= {shift_r[71:0], 1'b0};
                  latch_cnt_r <= '0;
                  if (!last_bit_s) begin
                     bit_cnt_r <= bit_cnt_r - 7'd1;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_W'(1'b1);
               end
            end
            LATCH: begin
               latch_cnt_r <= latch_cnt_r + LAT_W'(1'b1);
            end
            default: begin
               div_cnt_r <= '0;
            end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_s) state_s = SHIFT;
            else         state_s = IDLE;
         end
         SHIFT: begin
            if (bit_end_s && last_bit_s) state_s = LATCH;
            else                         state_s = SHIFT;
         end
         LATCH: begin
            if (latch_end_s) state_s = IDLE;
            else             state_s = LATCH;
         end
         default: state_s = IDLE;
      endcase
   end

   // Next values of the serial outputs; ser_data only moves at frame start or a ser_clk fall.
   always_comb begin
      ser_clk_s   = 1'b0;
      ser_data_s  = ser_data_r;
      ser_latch_s = 1'b0;
      busy_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               busy_s     = 1'b1;
               ser_data_s = tx_s[72];
            end else begin
               busy_s     = 1'b0;
            end
         end
         SHIFT: begin
            busy_s = 1'b1;
            if (bit_end_s) begin
               ser_clk_s = 1'b0;
               if (last_bit_s) begin
                  ser_latch_s = 1'b1;
               end else begin
                  ser_data_s  = shift_r[71];
               end
            end else if (div_cnt_r == DIV_HI_C) begin
               ser_clk_s = 1'b1;
            end else begin
               ser_clk_s = ser_clk_r;
            end
         end
         LATCH: begin
            if (latch_end_s) begin
               busy_s      = 1'b0;
               ser_latch_s = 1'b0;
            end else begin
               busy_s      = 1'b1;
               ser_latch_s = 1'b1;
            end
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   assign sout.ser_clk   = ser_clk_r;
   assign sout.ser_data  = ser_data_r;
   assign sout.ser_latch = ser_latch_r;
   assign sout.busy      = busy_r;

endmodule

// File: tb/tb_led_shift_out.sv
// Directed bench for led_shift_out: default build (CLK_DIV=4, LATCH_W=2) plus a CLK_DIV=1, LATCH_W=1 instance.
module tb_led_shift_out;
   localparam int CD = 4;
   localparam int LW = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] d1, d2, d3, d4, d5, d6, d7, d8;
   logic [8:0] sl;

   int checks = 0;
   int passed = 0;

   logic [72:0] f_bits;
   logic [72:0] exp_v;
   int          f_rises, f_busy, f_latch, f_high, f_viol, f_idle;
   bit          f_to;
   int          b2, r2, h2;

   always #5 clk = ~clk;

   led_shift_out_if s1 ();
   led_shift_out_if s2 ();

   led_shift_out #(.CLK_DIV(CD), .LATCH_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_1(d1), .disp_2(d2), .disp_3(d3), .disp_4(d4),
      .disp_5(d5), .disp_6(d6), .disp_7(d7), .disp_8(d8),
      .sl_in(sl), .sout(s1)
   );

   led_shift_out #(.CLK_DIV(1), .LATCH_W(1)) dut_fast (
      .clk(clk), .rst_n(rst_n),
      .disp_1(d1), .disp_2(d2), .disp_3(d3), .disp_4(d4),
      .disp_5(d5), .disp_6(d6), .disp_7(d7), .disp_8(d8),
      .sl_in(sl), .sout(s2)
   );

   // Reference frame: select word, then the 64 segment bits (inverted for common-anode builds).
   function automatic logic [72:0] exp_frame(logic [8:0] s, logic [7:0] a, logic [7:0] b, logic [7:0] c,
                                             logic [7:0] d, logic [7:0] e, logic [7:0] f, logic [7:0] g,
                                             logic [7:0] h);
      logic [63:0] seg;
      seg = {a, b, c, d, e, f, g, h};
`ifdef SEG_INVERT_EN
      seg = ~seg;
`endif
      return {s, seg};
   endfunction

   task automatic check_v(string tag, logic [72:0] obs, logic [72:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %019h expected %019h", tag, obs, exp);
   endtask

   task automatic check_i(string tag, int obs, int exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_b(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Waits (bounded) for the next frame on s1 and records it, sampling on falling clk edges.
   task automatic capture();
      logic pc, pd;
      int   n;
      f_bits = '0; f_rises = 0; f_busy = 0; f_latch = 0; f_high = 0; f_viol = 0; f_idle = 0; f_to = 1'b0;
      @(negedge clk);
      n = 0;
      while (s1.busy !== 1'b1 && n < 2000) begin
         f_idle++; n++;
         @(negedge clk);
      end
      if (n >= 2000) begin
         f_to = 1'b1;
         return;
      end
      pc = 1'b0;
      pd = s1.ser_data;
      while (s1.busy === 1'b1 && f_busy < 2000) begin
         f_busy++;
         if (s1.ser_clk === 1'b1 && pc === 1'b0) begin
            f_bits = {f_bits[71:0], s1.ser_data};
            f_rises++;
         end
         if (s1.ser_clk === 1'b1) f_high++;
         if (s1.ser_latch === 1'b1) f_latch++;
         if (s1.ser_data !== pd && !(pc === 1'b1 && s1.ser_clk === 1'b0)) f_viol++;
         if (s1.ser_latch === 1'b1 && s1.ser_clk !== 1'b0) f_viol++;
         pc = s1.ser_clk;
         pd = s1.ser_data;
         @(negedge clk);
      end
      if (f_busy >= 2000) f_to = 1'b1;
   endtask

   task automatic check_frame(string tag, logic [72:0] exp);
      check_b({tag, "_timeout"}, f_to, 1'b0);
      check_v({tag, "_bits"}, f_bits, exp);
      check_i({tag, "_rises"}, f_rises, 73);
      check_i({tag, "_busy"}, f_busy, 146 * CD + LW);
      check_i({tag, "_latch"}, f_latch, LW);
      check_i({tag, "_high"}, f_high, 73 * CD);
      check_i({tag, "_viol"}, f_viol, 0);
      check_b({tag, "_latch_off"}, s1.ser_latch, 1'b0);
   endtask

   initial begin
      d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; d4 = 8'h00;
      d5 = 8'h00; d6 = 8'h00; d7 = 8'h00; d8 = 8'h00;
      sl = 9'h000;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_b("rst_ser_clk", s1.ser_clk, 1'b0);
      check_b("rst_ser_data", s1.ser_data, 1'b0);
      check_b("rst_ser_latch", s1.ser_latch, 1'b0);
      check_b("rst_busy", s1.busy, 1'b0);

      // Init frame after reset release; the fast instance is measured alongside.
      rst_n = 1'b1;
      fork
         capture();
         begin
            logic p2;
            b2 = 0; r2 = 0; h2 = 0; p2 = 1'b0;
            @(negedge clk);
            while (s2.busy === 1'b1 && b2 < 1000) begin
               b2++;
               if (s2.ser_clk === 1'b1) h2++;
               if (s2.ser_clk === 1'b1 && p2 === 1'b0) r2++;
               p2 = s2.ser_clk;
               @(negedge clk);
            end
         end
      join
      check_i("init_idle_wait", f_idle, 0);
      check_frame("init", exp_frame(9'h000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));
      check_i("fast_busy", b2, 147);
      check_i("fast_rises", r2, 73);
      check_i("fast_high", h2, 73);
      repeat (20) @(negedge clk);
      check_b("idle_busy", s1.busy, 1'b0);
      check_b("idle_latch", s1.ser_latch, 1'b0);

      // Input change while idle: frame must start on the very next edge.
      d1 = 8'hFC; sl = 9'h100;
      capture();
      check_i("chg_idle_wait", f_idle, 0);
      check_frame("chg", exp_frame(9'h100, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00));

      // Change mid-frame: current frame keeps old data, next one follows after one idle cycle.
      repeat (5) @(negedge clk);
      d2 = 8'hAA;
      exp_v = exp_frame(9'h100, 8'hFC, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      fork
         capture();
         begin
            repeat (100) @(negedge clk);
            d8 = 8'h60;
         end
      join
      check_frame("mid_old", exp_v);
      capture();
      check_i("mid_gap", f_idle, 0);
      check_frame("mid_new", exp_frame(9'h100, 8'hFC, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60));

      // Reset during bit 30 (frame bit 42 = disp_3[2]) while ser_clk is high.
      repeat (5) @(negedge clk);
      d3 = 8'hFF;
      exp_v = exp_frame(9'h100, 8'hFC, 8'hAA, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60);
      @(negedge clk);
      repeat (30 * 2 * CD + CD + 1) @(negedge clk);
      check_b("pre_rst_busy", s1.busy, 1'b1);
      check_b("pre_rst_clk", s1.ser_clk, 1'b1);
      check_b("pre_rst_data", s1.ser_data, exp_v[42]);
      #2 rst_n = 1'b0;
      #1;
      check_b("async_ser_clk", s1.ser_clk, 1'b0);
      check_b("async_ser_data", s1.ser_data, 1'b0);
      check_b("async_ser_latch", s1.ser_latch, 1'b0);
      check_b("async_busy", s1.busy, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      capture();
      check_i("rerun_idle_wait", f_idle, 0);
      check_frame("rerun", exp_v);
      repeat (10) @(negedge clk);
      check_b("final_busy", s1.busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
